// File: rtl/udp_pkg.sv
// Shared constants and FSM state encoding for the IPv4/UDP receive path.
package udp_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4     = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP       = 8'd17;
  localparam int unsigned IPV4_MIN_HDR_BYTES = 20;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_OPT,
    ST_PAYLOAD,
    ST_DROP,
    ST_PAD
  } ip_state_e;

endpackage

// File: rtl/ip_csum_acc.sv
// Byte-serial IPv4 header checksum accumulator (16-bit one's-complement, end-around carry).
// sum_o includes the byte presented this cycle when valid_i is high.
module ip_csum_acc (
  input  logic        clk,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] sum_o
);

  logic [15:0] sum_q;
  logic        odd_q;
  logic [15:0] addend;
  logic [16:0] sum_raw;
  logic [15:0] sum_fold;

  // Even byte positions are the high half of each 16-bit header word.
  always_comb begin
    addend   = odd_q ? {8'h00, byte_i} : {byte_i, 8'h00};
    sum_raw  = {1'b0, sum_q} + {1'b0, addend};
    sum_fold = sum_raw[15:0] + {15'd0, sum_raw[16]};
    sum_o    = valid_i ? sum_fold : sum_q;
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      sum_q <= '0;
      odd_q <= 1'b0;
    end else if (valid_i) begin
      sum_q <= sum_fold;
      odd_q <= ~odd_q;
    end
  end

endmodule

// File: rtl/ip_parser.sv
// IPv4 header parser: filters UDP frames for TARGET_IP_ADDR and forwards the IP payload.
// Define IP_PARSER_CHECKSUM_EN to also require a valid header checksum.
module ip_parser
  import udp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter logic [31:0] TARGET_IP_ADDR = 32'hC0A8010A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  input  logic [17:0]           s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [48:0]           m_axis_tuser,
  output logic [15:0]           drop_count
);

  ip_state_e state_q;
  logic [15:0] cnt_q, tlen_q, plen_q, drop_q, etype_q;
  logic [7:0]  ver_ihl_q, proto_q;
  logic        mac_q, ferr_q;
  logic [31:0] src_q, dst_q;

  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q, m_last_q;
  logic [48:0]           m_user_q;

  logic        beat, in_hdr, in_opt, byte19, go_opt, hdr_last;
  logic        accept, csum_ok, last_by_len, drop_evt;
  logic [3:0]  ihl;
  logic [15:0] hdr_bytes, plen_now;
  logic [31:0] dst_now;
  logic [7:0]  in_byte;

  assign in_byte       = s_axis_tdata[7:0];
  assign s_axis_tready = (state_q == ST_PAYLOAD) ? (m_axis_tready | ~m_valid_q) : 1'b1;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign in_hdr        = (state_q == ST_HDR);
  assign in_opt        = (state_q == ST_OPT);
  assign ihl           = ver_ihl_q[3:0];
  assign hdr_bytes     = {10'd0, ihl, 2'b00};
  assign byte19        = in_hdr && (cnt_q == 16'(IPV4_MIN_HDR_BYTES - 1));
  assign go_opt        = byte19 && (ihl > 4'd5);
  assign hdr_last      = (byte19 && (ihl <= 4'd5)) || (in_opt && (cnt_q == hdr_bytes - 16'd1));
  // Last destination byte is still on the bus when IHL=5 evaluates.
  assign dst_now       = in_hdr ? {dst_q[31:8], in_byte} : dst_q;
  assign plen_now      = tlen_q - hdr_bytes;
  assign last_by_len   = ((cnt_q + 16'd1) == plen_q);

`ifdef IP_PARSER_CHECKSUM_EN
  logic [15:0] csum_sum;
  logic        csum_clear;

  assign csum_clear = rst | ~(in_hdr | in_opt) | (beat & (hdr_last | s_axis_tlast));

  ip_csum_acc u_csum (
    .clk     (clk),
    .clear_i (csum_clear),
    .valid_i (beat & (in_hdr | in_opt)),
    .byte_i  (in_byte),
    .sum_o   (csum_sum)
  );

  assign csum_ok = (csum_sum == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  assign accept = (etype_q == ETHERTYPE_IPV4) && mac_q && !ferr_q &&
                  (ver_ihl_q[7:4] == 4'd4) && (ihl >= 4'd5) &&
                  (proto_q == IP_PROTO_UDP) && (dst_now == TARGET_IP_ADDR) &&
                  (tlen_q >= hdr_bytes) && csum_ok;

  always_comb begin
    drop_evt = 1'b0;
    if (beat) begin
      case (state_q)
        ST_HDR, ST_OPT: drop_evt = s_axis_tlast && !(hdr_last && accept && (plen_now == '0));
        ST_DROP:        drop_evt = s_axis_tlast;
        default:        drop_evt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HDR;
      cnt_q     <= '0;
      tlen_q    <= '0;
      plen_q    <= '0;
      etype_q   <= '0;
      ver_ihl_q <= '0;
      proto_q   <= '0;
      mac_q     <= 1'b0;
      ferr_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_user_q  <= '0;
      drop_q    <= '0;
    end else begin
      if (drop_evt && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      if (m_valid_q && m_axis_tready) m_valid_q <= 1'b0;
      if (beat) begin
        case (state_q)
          ST_HDR, ST_OPT: begin
            if (in_hdr) begin
              case (cnt_q)
                16'd0: begin
                  ver_ihl_q <= in_byte;
                  etype_q   <= s_axis_tuser[15:0];
                  mac_q     <= s_axis_tuser[16];
                  ferr_q    <= s_axis_tuser[17];
                end
                16'd2:  tlen_q[15:8]  <= in_byte;
                16'd3:  tlen_q[7:0]   <= in_byte;
                16'd9:  proto_q       <= in_byte;
                16'd12: src_q[31:24]  <= in_byte;
                16'd13: src_q[23:16]  <= in_byte;
                16'd14: src_q[15:8]   <= in_byte;
                16'd15: src_q[7:0]    <= in_byte;
                16'd16: dst_q[31:24]  <= in_byte;
                16'd17: dst_q[23:16]  <= in_byte;
                16'd18: dst_q[15:8]   <= in_byte;
                16'd19: dst_q[7:0]    <= in_byte;
                default: ;
              endcase
            end
            if (hdr_last) begin
              cnt_q  <= '0;
              plen_q <= plen_now;
              if (s_axis_tlast)       state_q <= ST_HDR;
              else if (!accept)       state_q <= ST_DROP;
              else if (plen_now == '0) state_q <= ST_PAD;
              else                    state_q <= ST_PAYLOAD;
            end else if (s_axis_tlast) begin
              state_q <= ST_HDR;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
              if (go_opt) state_q <= ST_OPT;
            end
          end
          ST_PAYLOAD: begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_axis_tdata;
            m_last_q  <= last_by_len | s_axis_tlast;
            m_user_q  <= {s_axis_tlast & ~last_by_len, plen_q, src_q};
            if (s_axis_tlast) begin
              state_q <= ST_HDR;
              cnt_q   <= '0;
            end else if (last_by_len) begin
              state_q <= ST_PAD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          ST_DROP, ST_PAD: if (s_axis_tlast) state_q <= ST_HDR;
          default: state_q <= ST_HDR;
        endcase
      end
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_ip_parser.sv
// Directed bench for ip_parser with a frame-level reference model and per-cycle output checker.
module tb_ip_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [17:0] s_tuser;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [48:0] m_tuser;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  ip_parser #(.DATA_WIDTH(8), .TARGET_IP_ADDR(32'hC0A8010A)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser),
    .drop_count    (drop_count)
  );

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic [48:0] u;
  } beat_t;

  localparam logic [17:0] U_OK = {1'b0, 1'b1, 16'h0800};
  localparam logic [31:0] DST_OK = 32'hC0A8010A;

  int errors = 0;
  int checks = 0;
  int exp_drops = 0;
  int rx_beats = 0;
  logic tog = 1'b0;
  logic in_rst = 1'b1;
  beat_t exp_q[$];
  logic [7:0] frm[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame builder: IPv4 header with valid checksum (optionally corrupted), zero options, payload A0.., pad 55.
  task automatic build_frame(input int ihl, input int tlen, input logic [7:0] proto,
                             input logic [31:0] dst, input int npay, input int npad, input logic bad);
    logic [7:0]  h[64];
    logic [31:0] s;
    logic [15:0] ck, tl;
    logic [31:0] src;
    src = 32'h0A000001;
    tl  = tlen[15:0];
    for (int i = 0; i < 64; i++) h[i] = '0;
    h[0] = {4'd4, ihl[3:0]};
    h[2] = tl[15:8];  h[3] = tl[7:0];
    h[8] = 8'd64;     h[9] = proto;
    h[12] = src[31:24]; h[13] = src[23:16]; h[14] = src[15:8]; h[15] = src[7:0];
    h[16] = dst[31:24]; h[17] = dst[23:16]; h[18] = dst[15:8]; h[19] = dst[7:0];
    s = 0;
    for (int i = 0; i < 4 * ihl; i += 2) s = s + {16'd0, h[i], h[i+1]};
    while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    ck = ~s[15:0];
    h[10] = ck[15:8] ^ (bad ? 8'h01 : 8'h00);
    h[11] = ck[7:0];
    frm.delete();
    for (int i = 0; i < 4 * ihl; i++) frm.push_back(h[i]);
    for (int i = 0; i < npay; i++) frm.push_back(8'(8'hA0 + i));
    for (int i = 0; i < npad; i++) frm.push_back(8'h55);
  endtask

  // Reference model: decides the fate of the whole frame from its bytes.
  task automatic model_frame(input logic [17:0] user);
    int n, ihl, hb, avail, nb;
    logic [15:0] tl, plen;
    logic [31:0] src, dst, s;
    logic acc;
    n = frm.size();
    if (n < 20) begin exp_drops++; return; end
    ihl = int'(frm[0][3:0]);
    hb  = 4 * ihl;
    tl  = {frm[2], frm[3]};
    src = {frm[12], frm[13], frm[14], frm[15]};
    dst = {frm[16], frm[17], frm[18], frm[19]};
    acc = (user[15:0] == 16'h0800) && user[16] && !user[17] && (frm[0][7:4] == 4'd4) &&
          (ihl >= 5) && (frm[9] == 8'd17) && (dst == DST_OK) && (int'(tl) >= hb) && (n >= hb);
`ifdef IP_PARSER_CHECKSUM_EN
    if (acc) begin
      s = 0;
      for (int i = 0; i < hb; i += 2) s = s + {16'd0, frm[i], frm[i+1]};
      while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      acc = (s[15:0] == 16'hFFFF);
    end
`endif
    if (!acc) begin exp_drops++; return; end
    plen  = tl - 16'(hb);
    avail = n - hb;
    if (plen == 0) return;
    if (avail == 0) begin exp_drops++; return; end
    nb = (avail < int'(plen)) ? avail : int'(plen);
    for (int i = 0; i < nb; i++)
      exp_q.push_back('{d: frm[hb+i], l: (i == nb - 1),
                        u: {(i == nb - 1) && (avail < int'(plen)), plen, src}});
  endtask

  task automatic send_bytes(input int cnt, input logic with_last, input logic [17:0] user);
    logic hs;
    int t;
    @(posedge clk); #1;
    for (int i = 0; i < cnt; i++) begin
      s_tdata  = frm[i];
      s_tvalid = 1'b1;
      s_tlast  = with_last && (i == cnt - 1);
      s_tuser  = user;
      t = 0;
      do begin
        @(negedge clk);
        hs = s_tready;
        t++;
        @(posedge clk); #1;
      end while (!hs && t < 1000);
      if (!hs) begin
        errors++; checks++;
        $display("FAIL input_handshake_timeout: got tready=0 for %0d cycles expected acceptance", t);
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain_and_check(input string name, input int exp_beats);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_beats"}, 64'(rx_beats), 64'(exp_beats));
    chk({name, "_drops"}, 64'(drop_count), 64'(exp_drops));
  endtask

  task automatic run_frame(input string name, input logic [17:0] user, input int exp_beats);
    rx_beats = 0;
    model_frame(user);
    send_bytes(frm.size(), 1'b1, user);
    drain_and_check(name, exp_beats);
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = tog ? ~m_tready : 1'b1;
    end
  end

  // Per-cycle output checker: in-order beats against the model, and hold while stalled.
  logic        stall_q = 1'b0;
  logic [7:0]  pd;
  logic        pl;
  logic [48:0] pu;
  beat_t       e;
  always @(negedge clk) begin
    if (in_rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("stall_valid", 64'(m_tvalid), 64'd1);
        chk("stall_hold", {6'd0, m_tdata, m_tlast, m_tuser}, {6'd0, pd, pl, pu});
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_beat: got data %0h expected no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(m_tdata), 64'(e.d));
          chk("beat_last", 64'(m_tlast), 64'(e.l));
          chk("beat_user", 64'(m_tuser), 64'(e.u));
          rx_beats++;
        end
      end
      stall_q = m_tvalid && !m_tready;
      pd = m_tdata; pl = m_tlast; pu = m_tuser;
    end
  end

  initial begin
    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; in_rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tuser", 64'(m_tuser), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd1);

    // Basic accepted frame, with literal pins on the model output.
    build_frame(5, 28, 8'd17, DST_OK, 8, 0, 1'b0);
    rx_beats = 0;
    model_frame(U_OK);
    chk("pin_count", 64'(exp_q.size()), 64'd8);
    chk("pin_src", 64'(exp_q[0].u[31:0]), 64'h0A000001);
    chk("pin_len", 64'(exp_q[7].u[47:32]), 64'd8);
    chk("pin_last", {55'd0, exp_q[7].d, exp_q[7].l}, {55'd0, 8'hA7, 1'b1});
    send_bytes(frm.size(), 1'b1, U_OK);
    drain_and_check("valid", 8);

    build_frame(5, 28, 8'd6, DST_OK, 8, 0, 1'b0);
    run_frame("proto6", U_OK, 0);
    build_frame(5, 28, 8'd17, 32'hC0A8010B, 8, 0, 1'b0);
    run_frame("wrong_dst", U_OK, 0);
    chk("drops_literal", 64'(drop_count), 64'd2);

    build_frame(6, 30, 8'd17, DST_OK, 6, 16, 1'b0);
    run_frame("ihl6_pad", U_OK, 6);
    build_frame(5, 28, 8'd17, DST_OK, 8, 0, 1'b0);
    run_frame("after_pad", U_OK, 8);

    tog = 1'b1;
    run_frame("backpressure", U_OK, 8);
    tog = 1'b0;

    build_frame(5, 28, 8'd17, DST_OK, 8, 0, 1'b1);
`ifdef IP_PARSER_CHECKSUM_EN
    run_frame("bad_csum", U_OK, 0);
`else
    run_frame("bad_csum", U_OK, 8);
`endif

    build_frame(5, 40, 8'd17, DST_OK, 5, 0, 1'b0);
    rx_beats = 0;
    model_frame(U_OK);
    chk("pin_trunc", {62'd0, exp_q[4].u[48], exp_q[4].l}, {62'd0, 1'b1, 1'b1});
    send_bytes(frm.size(), 1'b1, U_OK);
    drain_and_check("truncated", 5);

    build_frame(5, 28, 8'd17, DST_OK, 8, 0, 1'b0);
    run_frame("frame_err", {1'b1, 1'b1, 16'h0800}, 0);
    run_frame("mac_miss", {1'b0, 1'b0, 16'h0800}, 0);
    run_frame("ethertype", {1'b0, 1'b1, 16'h86DD}, 0);

    build_frame(5, 20, 8'd17, DST_OK, 0, 6, 1'b0);
    run_frame("zero_len", U_OK, 0);

    build_frame(5, 28, 8'd17, DST_OK, 8, 0, 1'b0);
    while (frm.size() > 11) void'(frm.pop_back());
    run_frame("short_hdr", U_OK, 0);

    // Reset in the middle of a header, then a clean frame.
    build_frame(5, 28, 8'd17, DST_OK, 8, 0, 1'b0);
    send_bytes(7, 1'b0, U_OK);
    @(posedge clk); #1;
    rst = 1'b1; in_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_rst = 1'b0;
    exp_q.delete();
    exp_drops = 0;
    @(negedge clk);
    chk("midrst_drops", 64'(drop_count), 64'd0);
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    run_frame("after_reset", U_OK, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ip_parser.md
IP_PARSER -- requirements
Module: ip_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, stream byte width (only 8 supported).
REQ-002 SHALL have parameter TARGET_IP_ADDR, default 32'hC0A8010A, accepted destination IPv4 address.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have s_axis_tdata/tvalid/tlast/tready  in/in/in/out  8/1/1/1  Ethernet payload stream from the eth_parser stage.
REQ-006 SHALL have s_axis_tuser  input  18  [15:0] ethertype, [16] MAC match, [17] frame error; sampled on the first beat of a frame.
REQ-007 SHALL have m_axis_tdata/tvalid/tlast/tready  out/out/out/in  8/1/1/1  IPv4 payload stream to the UDP stage.
REQ-008 SHALL have m_axis_tuser  output  49  [31:0] source IP, [47:32] payload length (total_length - 4*IHL), [48] truncated; constant for the whole frame.
REQ-009 SHALL have drop_count  output  16  saturating count of dropped frames.

Function
REQ-010 SHALL use FSM states HDR, OPT, PAYLOAD, DROP, PAD; HDR after reset and after every input tlast.
REQ-011 HDR SHALL count bytes 0..19 and capture version/IHL (byte 0), total_length (2-3), protocol (9), source IP (12-15), destination IP (16-19).
REQ-012 On byte 19: if IHL>5, go to OPT and discard 4*IHL-20 option bytes; otherwise evaluate acceptance on that byte.
REQ-013 Accept SHALL require ethertype 16'h0800, MAC match=1, frame error=0, version=4, IHL>=5, protocol=17, destination IP==TARGET_IP_ADDR, and total_length>=4*IHL; otherwise go to DROP.
REQ-014 DROP SHALL hold s_axis_tready=1 until the input tlast, then return to HDR and increment drop_count (saturating at 16'hFFFF).
REQ-015 An input tlast arriving in HDR/OPT before the header completes SHALL drop the frame (counted) and return to HDR.
REQ-016 PAYLOAD SHALL forward bytes with a single registered output stage; s_axis_tready = m_axis_tready | ~m_axis_tvalid; latency one cycle.
REQ-017 m_axis_tlast SHALL assert on payload byte number (payload length); remaining input bytes (Ethernet padding) SHALL be consumed in PAD without output, leaving PAD on input tlast.
REQ-018 If input tlast arrives before payload length is reached, that byte SHALL carry m_axis_tlast=1 and m_axis_tuser[48]=1.
REQ-019 Payload length 0 SHALL produce no output beats and SHALL NOT count as a drop.
REQ-020 m_axis_tvalid SHALL NOT deassert and m_axis_tdata/tlast/tuser SHALL NOT change while tvalid=1 and tready=0.
REQ-021 In HDR, OPT, DROP and PAD, s_axis_tready SHALL be 1.

Reset
REQ-022 rst SHALL set state=HDR, byte counter=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, drop_count=0, checksum accumulator=0.
REQ-023 rst mid-frame SHALL abandon the frame with no output tlast; the bytes following reset are parsed as a new header.

Configuration
REQ-024 With IP_PARSER_CHECKSUM_EN defined, the one's-complement sum over all 4*IHL header bytes (16-bit words, end-around carry) SHALL equal 16'hFFFF for acceptance; a mismatch drops the frame.
REQ-025 Without IP_PARSER_CHECKSUM_EN, no checksum logic SHALL be present and the header checksum SHALL be ignored.

Structure
REQ-026 Shared package udp_pkg SHALL hold ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'd17, IPV4_MIN_HDR_BYTES=20 and the FSM state encoding.
REQ-027 Checksum accumulation SHALL live in sub-module ip_csum_acc (byte in, valid, clear, 16-bit folded sum out), instantiated only under IP_PARSER_CHECKSUM_EN.

Verification
REQ-028 Valid UDP/IPv4 frame, IHL=5, total_length=28, 8 payload bytes 0xA0..0xA7, src 10.0.0.1 -> 8 beats, tlast on 0xA7, tuser[31:0]=32'h0A000001, tuser[47:32]=8, drop_count=0.
REQ-029 Same frame with protocol=6, then with dst 192.168.1.11 -> no output beats, drop_count=2.
REQ-030 IHL=6 (4 option bytes), total_length=30, 6 payload bytes followed by 16 pad bytes -> 6 output beats, pad discarded, next frame parsed correctly.
REQ-031 m_axis_tready toggled 1/0 every cycle on the REQ-028 frame -> identical byte sequence, no drops or duplicates, data stable while stalled.
REQ-032 Checksum byte corrupted: with IP_PARSER_CHECKSUM_EN -> dropped, drop_count=1; without -> forwarded.
REQ-033 total_length=40 but input tlast after 5 payload bytes -> 5 beats, tlast and tuser[48]=1 on the 5th; rst asserted mid-header -> next frame parsed cleanly.
